// File: rtl/gmii_arb_pkg.sv
// rtl/gmii_arb_pkg.sv - shared types and defaults for the GMII transmit arbiter
package gmii_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_XFER  = 2'd1,
    ARB_DRAIN = 2'd2,
    ARB_IFG   = 2'd3
  } arb_state_t;

  // Ethernet inter-frame gap in byte times
  localparam int DEF_IFG_CYCLES = 12;

  // Largest untagged Ethernet frame including FCS
  localparam int DEF_MAX_BYTES = 1518;

endpackage

// File: rtl/gmii_tx_arbiter_if.sv
// rtl/gmii_tx_arbiter_if.sv - source lanes and transmit byte path of the arbiter
interface gmii_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   src_req;
  logic [8*N_REQ-1:0] src_data;
  logic [N_REQ-1:0]   src_valid;
  logic [N_REQ-1:0]   src_last;
  logic [N_REQ-1:0]   src_ready;

  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_last;
  logic               tx_ready;

  // Arbiter view: consumes source lanes, drives the transmit path
  modport master (
    input  src_req, src_data, src_valid, src_last, tx_ready,
    output src_ready, tx_data, tx_valid, tx_last
  );

  // Environment view: sources plus the transmit datapath
  modport slave (
    output src_req, src_data, src_valid, src_last, tx_ready,
    input  src_ready, tx_data, tx_valid, tx_last
  );

endinterface

// File: rtl/gmii_tx_arbiter_rr_picker.sv
// rtl/gmii_tx_arbiter_rr_picker.sv - rotating priority encoder for the arbiter
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             found
);

  // Scan upward from ptr, wrapping modulo N_REQ; first requester wins
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_REQ)) begin
        sum = sum - (PTR_W+1)'(N_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// rtl/gmii_tx_arbiter.sv - round-robin frame arbiter in front of the GMII transmit path
module gmii_tx_arbiter
  import gmii_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IFG_CYCLES = DEF_IFG_CYCLES,
  parameter int MAX_BYTES  = DEF_MAX_BYTES
) (
  input  logic                 eth_tx_clk,
  input  logic                 eth_rst,
  gmii_tx_arbiter_if.master    bus,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 oversize_err,
  output logic [15:0]          frames_sent
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [15:0]       byte_cnt;
  logic [15:0]       ifg_cnt;

  logic [N_REQ-1:0]  pick;
  logic              found;
  logic [PTR_W-1:0]  pick_idx;

  logic [7:0]        lane_data;
  logic              lane_valid;
  logic              lane_last;

  logic              at_max;
  logic              xfer_beat;
  logic              drain_beat;
  logic              frame_done;
  logic              ifg_done;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (bus.src_req),
    .ptr   (rr_ptr),
    .pick  (pick),
    .found (found)
  );

  // Select the byte lane of the current owner; all-zero when nobody holds the grant
  always_comb begin
    lane_data  = '0;
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        lane_data  = bus.src_data[8*i +: 8];
        lane_valid = bus.src_valid[i];
        lane_last  = bus.src_last[i];
      end
    end
  end

  // Binary index of the picker's winner, used to advance the round-robin pointer
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  assign at_max     = (byte_cnt == 16'(MAX_BYTES - 1));
  assign xfer_beat  = (state == ARB_XFER) && lane_valid && bus.tx_ready;
  assign drain_beat = (state == ARB_DRAIN) && lane_valid;
  assign frame_done = xfer_beat && (lane_last || at_max);
  assign ifg_done   = (ifg_cnt == 16'(IFG_CYCLES - 1));

  // State register; reset abandons any frame in flight
  always_ff @(posedge eth_tx_clk or negedge eth_rst) begin
    if (!eth_rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: truncation diverts to DRAIN so the rest of the source frame is swallowed
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (found) state_nxt = ARB_XFER;
      end
      ARB_XFER: begin
        if (xfer_beat) begin
          if (lane_last)   state_nxt = ARB_IFG;
          else if (at_max) state_nxt = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        if (drain_beat && lane_last) state_nxt = ARB_IFG;
      end
      ARB_IFG: begin
        if (ifg_done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs: transmit path only sees the owner's lane while in XFER
  always_comb begin
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;
    bus.tx_last   = 1'b0;
    bus.src_ready = '0;
    oversize_err  = 1'b0;
    busy          = (state != ARB_IDLE);
    case (state)
      ARB_XFER: begin
        bus.tx_data   = lane_data;
        bus.tx_valid  = lane_valid;
        bus.tx_last   = lane_last || at_max;
        bus.src_ready = grant & {N_REQ{bus.tx_ready}};
        oversize_err  = xfer_beat && !lane_last && at_max;
      end
      ARB_DRAIN: begin
        bus.src_ready = grant;
      end
      default: ;
    endcase
  end

  // Grant, pointer and counters; grant drops as the gap starts
  always_ff @(posedge eth_tx_clk or negedge eth_rst) begin
    if (!eth_rst) begin
      grant       <= '0;
      rr_ptr      <= '0;
      byte_cnt    <= '0;
      ifg_cnt     <= '0;
      frames_sent <= '0;
    end else begin
      if (state == ARB_IDLE && found) begin
        grant    <= pick;
        rr_ptr   <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
        byte_cnt <= '0;
      end else if (xfer_beat) begin
        byte_cnt <= byte_cnt + 16'd1;
      end
      if (frame_done) begin
        frames_sent <= frames_sent + 16'd1;
      end
      if (state_nxt == ARB_IFG && state != ARB_IFG) begin
        grant   <= '0;
        ifg_cnt <= '0;
      end else if (state == ARB_IFG) begin
        ifg_cnt <= ifg_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb/tb_gmii_tx_arbiter.sv - directed self-checking bench for gmii_tx_arbiter
module tb_gmii_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gmii_tx_arbiter_if #(.N_REQ(4)) if_a ();
  gmii_tx_arbiter_if #(.N_REQ(4)) if_b ();

  logic [3:0]  grant_a, grant_b;
  logic        busy_a, busy_b, oerr_a, oerr_b;
  logic [15:0] fs_a, fs_b;

  gmii_tx_arbiter #(.N_REQ(4), .IFG_CYCLES(12), .MAX_BYTES(1518)) dut_a (
    .eth_tx_clk (clk), .eth_rst (rst_n), .bus (if_a.master),
    .grant (grant_a), .busy (busy_a), .oversize_err (oerr_a), .frames_sent (fs_a)
  );

  gmii_tx_arbiter #(.N_REQ(4), .IFG_CYCLES(12), .MAX_BYTES(16)) dut_b (
    .eth_tx_clk (clk), .eth_rst (rst_n), .bus (if_b.master),
    .grant (grant_b), .busy (busy_b), .oversize_err (oerr_b), .frames_sent (fs_b)
  );

  logic        sel;
  logic [3:0]  req, valid, last;
  logic [31:0] data;
  logic        tx_ready;

  assign if_a.src_req   = sel ? 4'b0 : req;
  assign if_a.src_valid = sel ? 4'b0 : valid;
  assign if_a.src_last  = sel ? 4'b0 : last;
  assign if_a.src_data  = data;
  assign if_a.tx_ready  = tx_ready;
  assign if_b.src_req   = sel ? req : 4'b0;
  assign if_b.src_valid = sel ? valid : 4'b0;
  assign if_b.src_last  = sel ? last : 4'b0;
  assign if_b.src_data  = data;
  assign if_b.tx_ready  = tx_ready;

  wire [3:0]  o_grant = sel ? grant_b : grant_a;
  wire [3:0]  o_rdy   = sel ? if_b.src_ready : if_a.src_ready;
  wire [7:0]  o_txd   = sel ? if_b.tx_data : if_a.tx_data;
  wire        o_txv   = sel ? if_b.tx_valid : if_a.tx_valid;
  wire        o_txl   = sel ? if_b.tx_last : if_a.tx_last;
  wire        o_busy  = sel ? busy_b : busy_a;
  wire        o_oerr  = sel ? oerr_b : oerr_a;
  wire [15:0] o_fs    = sel ? fs_b : fs_a;

  int total = 0;
  int bad = 0;

  // source model: frame length, byte position, active and auto-repeat flags
  int len [4];
  int pos [4];
  bit act [4];
  bit rep [4];
  bit toggle;

  // per-cycle samples taken on the falling edge
  int         cyc = 0;
  logic [3:0] s_grant, s_rdy, s_src_beat, s_src_last_beat;
  logic       s_txv, s_txl, s_busy, s_oerr, s_beat, s_trdy;
  logic [7:0] s_txd;
  logic [15:0] s_fs;

  // transmit-side tallies
  int nb, nlast, last_at, last_cyc, derr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]          = act[i];
      valid[i]        = act[i];
      last[i]         = act[i] && (pos[i] == len[i] - 1);
      data[8*i +: 8]  = 8'(pos[i] + 64 * i);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      len[i] = 1; pos[i] = 0; act[i] = 1'b0; rep[i] = 1'b0;
    end
    toggle   = 1'b0;
    tx_ready = 1'b1;
    drive();
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    s_grant = o_grant; s_rdy = o_rdy; s_txd = o_txd; s_txv = o_txv; s_txl = o_txl;
    s_busy = o_busy; s_oerr = o_oerr; s_fs = o_fs; s_trdy = tx_ready;
    s_beat = o_txv && tx_ready;
    s_src_beat = valid & o_rdy;
    s_src_last_beat = s_src_beat & last;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (s_src_beat[i]) begin
        if (last[i]) begin
          pos[i] = 0;
          act[i] = rep[i];
        end else begin
          pos[i]++;
        end
      end
    end
    if (toggle) tx_ready = ~tx_ready;
    drive();
  endtask

  task automatic clear_tally();
    nb = 0; nlast = 0; last_at = 0; last_cyc = 0; derr = 0;
  endtask

  task automatic tally(input int base);
    if (s_beat) begin
      if (s_txd !== 8'(base + nb)) derr++;
      nb++;
      if (s_txl) begin
        nlast++;
        last_at  = nb;
        last_cyc = cyc;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rst_vals(input string p);
    check_eq({p, "_grant"}, o_grant, 0);
    check_eq({p, "_src_ready"}, o_rdy, 0);
    check_eq({p, "_tx_valid"}, o_txv, 0);
    check_eq({p, "_tx_last"}, o_txl, 0);
    check_eq({p, "_tx_data"}, o_txd, 0);
    check_eq({p, "_busy"}, o_busy, 0);
    check_eq({p, "_oversize"}, o_oerr, 0);
    check_eq({p, "_frames"}, o_fs, 0);
  endtask

  // start a long frame on src, pull reset low after its fifth byte
  task automatic mid_reset(input int src, input string p);
    clear_tally();
    act[src] = 1'b1; len[src] = 30;
    drive();
    for (int k = 0; k < 40 && nb < 5; k++) begin
      step();
      tally(64 * src);
    end
    check_eq({p, "_five_beats"}, nb, 5);
    rst_n = 1'b0;
    #1;
    check_eq({p, "_async_txv"}, o_txv, 0);
    clear_model();
    @(negedge clk);
    rst_vals(p);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int order [6];
  int n_ord, nifg, nxt, merr, noerr, oerr_at, ndrain, src_last_cyc, drop_cyc;
  logic [3:0] prevg;
  logic [3:0] exp_rdy;

  initial begin
    sel = 1'b0;
    clear_model();
    #12;
    rst_vals("reset");

    // single source, 64-byte frame, then the same source again to time the gap
    do_reset();
    act[2] = 1'b1; len[2] = 64; rep[2] = 1'b1;
    drive();
    clear_tally();
    step();
    check_eq("t1_grant_before", s_grant, 4'b0000);
    step();
    check_eq("t1_grant_after", s_grant, 4'b0100);
    tally(128);
    for (int k = 0; k < 200 && nlast == 0; k++) begin
      step();
      tally(128);
    end
    rep[2] = 1'b0;
    check_eq("t1_beats", nb, 64);
    check_eq("t1_last_pos", last_at, 64);
    check_eq("t1_data", derr, 0);
    step();
    check_eq("t1_frames", s_fs, 1);
    nifg = 0; nxt = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      if (s_busy && s_grant == 4'b0) nifg++;
      if (s_beat) begin
        nxt = cyc;
        break;
      end
    end
    check_eq("t1_ifg_cycles", nifg, 12);
    check_eq("t1_gap", nxt - last_cyc, 14);

    // fairness: all four sources request 10-byte frames back to back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      act[i] = 1'b1; len[i] = 10; rep[i] = 1'b1;
    end
    drive();
    prevg = 4'b0; n_ord = 0;
    for (int k = 0; k < 400 && n_ord < 6; k++) begin
      step();
      if (s_grant != 4'b0 && prevg == 4'b0) begin
        order[n_ord] = -1;
        for (int i = 0; i < 4; i++) if (s_grant == 4'(1 << i)) order[n_ord] = i;
        n_ord++;
      end
      prevg = s_grant;
    end
    check_eq("t2_grants_seen", n_ord, 6);
    for (int k = 0; k < 6; k++) check_eq($sformatf("t2_grant_%0d", k), order[k], k % 4);

    // backpressure: tx_ready alternates every cycle during a 20-byte frame
    do_reset();
    act[1] = 1'b1; len[1] = 20; toggle = 1'b1;
    drive();
    clear_tally();
    merr = 0;
    for (int k = 0; k < 100 && nlast == 0; k++) begin
      step();
      tally(64);
      exp_rdy = (s_grant == 4'b0010) ? {2'b00, s_trdy, 1'b0} : 4'b0000;
      if (s_rdy !== exp_rdy) merr++;
    end
    check_eq("t3_beats", nb, 20);
    check_eq("t3_last_pos", last_at, 20);
    check_eq("t3_data", derr, 0);
    check_eq("t3_ready_mirror", merr, 0);

    // oversize: 25-byte frame into the instance limited to 16 bytes
    do_reset();
    sel = 1'b1;
    act[0] = 1'b1; len[0] = 25;
    drive();
    clear_tally();
    noerr = 0; oerr_at = -1; ndrain = 0; src_last_cyc = -1; drop_cyc = -1; prevg = 4'b0;
    for (int k = 0; k < 100 && drop_cyc < 0; k++) begin
      step();
      tally(0);
      if (s_oerr) begin
        noerr++;
        oerr_at = nb;
      end
      if (s_src_beat[0] && !s_txv) ndrain++;
      if (s_src_last_beat[0]) src_last_cyc = cyc;
      if (prevg != 4'b0 && s_grant == 4'b0) drop_cyc = cyc;
      prevg = s_grant;
    end
    check_eq("t4_beats", nb, 16);
    check_eq("t4_last_pos", last_at, 16);
    check_eq("t4_data", derr, 0);
    check_eq("t4_oversize_pulses", noerr, 1);
    check_eq("t4_oversize_at", oerr_at, 16);
    check_eq("t4_drained", ndrain, 9);
    check_eq("t4_ifg_after_src_last", drop_cyc - src_last_cyc, 1);
    check_eq("t4_frames", s_fs, 1);

    // reset mid-frame
    do_reset();
    sel = 1'b0;
    act[3] = 1'b1; len[3] = 3;
    drive();
    for (int k = 0; k < 60; k++) begin
      step();
      if (s_fs == 16'd1 && !s_busy) break;
    end
    check_eq("t5_pre_frames", s_fs, 1);
    check_eq("t5_pre_idle", s_busy, 0);
    mid_reset(0, "t5a");
    act[1] = 1'b1; len[1] = 2;
    drive();
    step();
    step();
    check_eq("t5_grant_src1", s_grant, 4'b0010);
    for (int k = 0; k < 40; k++) begin
      step();
      if (!s_busy) break;
    end
    check_eq("t5_idle_again", s_busy, 0);
    check_eq("t5_frames_restart", s_fs, 1);
    mid_reset(0, "t5b");
    act[0] = 1'b1; len[0] = 4;
    act[1] = 1'b1; len[1] = 4;
    drive();
    step();
    step();
    check_eq("t5_tie_src0", s_grant, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
